// File: rtl/ps_mac_pkg.sv
// Shared definitions for the precision-scalable digit-serial MAC.
//   state_t      : controller states
//   PREC_*       : prec field encodings (operand width select)
//   SGN_*        : sgn field encodings ({a_signed, b_signed})
//   eff_digits() : number of 2-bit digits for a prec value, clamped to max_w
//   mfu2()       : 2-bit x 2-bit multi-format multiplier slice
package ps_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [1:0] PREC_2B  = 2'b00;
    localparam logic [1:0] PREC_4B  = 2'b01;
    localparam logic [1:0] PREC_8B  = 2'b10;
    localparam logic [1:0] PREC_16B = 2'b11;

    localparam logic [1:0] SGN_UU = 2'b00;
    localparam logic [1:0] SGN_US = 2'b01;
    localparam logic [1:0] SGN_SU = 2'b10;
    localparam logic [1:0] SGN_SS = 2'b11;

    // Digits per operand: W/2 with W = min(2 << prec, max_w).
    function automatic int eff_digits(input logic [1:0] prec, input int max_w);
        int w;
        w = 2 << prec;
        if (w > max_w) w = max_w;
        return w / 2;
    endfunction

    // sel = {x_signed, y_signed}. Product range is -6..9, fits 5 bits signed.
    function automatic logic signed [4:0] mfu2(input logic [1:0] x,
                                               input logic [1:0] y,
                                               input logic [1:0] sel);
        logic signed [2:0] xs;
        logic signed [2:0] ys;
        logic signed [5:0] p;
        xs = {sel[1] & x[1], x};
        ys = {sel[0] & y[1], y};
        p  = xs * ys;
        return p[4:0];
    endfunction

endpackage

// File: rtl/ps_mac_if.sv
// Operand/result handshake bundle for ps_mac_seq.
//   in_valid/in_ready   : operand pair handshake (a, b, prec, sgn, acc_clr, last)
//   out_valid/out_ready : result handshake (acc_out)
// master = operand source / result sink, slave = the MAC.
interface ps_mac_if #(
    parameter int MAX_W = 8,
    parameter int ACC_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [MAX_W-1:0] a;
    logic [MAX_W-1:0] b;
    logic [1:0]       prec;
    logic [1:0]       sgn;
    logic             acc_clr;
    logic             last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;

    modport master (
        output in_valid, a, b, prec, sgn, acc_clr, last, out_ready,
        input  in_ready, out_valid, acc_out
    );

    modport slave (
        input  in_valid, a, b, prec, sgn, acc_clr, last, out_ready,
        output in_ready, out_valid, acc_out
    );
endinterface

// File: rtl/ps_digit_row.sv
// Combinational row product: A x one 2-bit digit of B.
//   a            : operand A (only digits below n_digits are used)
//   digit        : current 2-bit digit of B
//   a_signed     : A is two's complement (affects its top active digit only)
//   digit_signed : digit is the signed top digit of B
//   n_digits     : active digit count D
//   row          : signed row product, sign-extended to MAX_W+3 bits
module ps_digit_row
    import ps_mac_pkg::*;
#(
    parameter int MAX_W = 8
) (
    input  logic [MAX_W-1:0]         a,
    input  logic [1:0]               digit,
    input  logic                     a_signed,
    input  logic                     digit_signed,
    input  logic [$clog2(MAX_W)-1:0] n_digits,
    output logic signed [MAX_W+2:0]  row
);
    localparam int ND  = MAX_W / 2;
    localparam int RW  = MAX_W + 3;
    localparam int J_W = $clog2(MAX_W);

    logic signed [4:0] slice_p [ND];

    for (genvar i = 0; i < ND; i++) begin : g_slice
        logic       active;
        logic       top;
        logic [1:0] a_dig;
        assign active = (J_W'(i) < n_digits);
        assign top    = (J_W'(i) == n_digits - 1'b1);
        // Digits beyond the selected width contribute nothing.
        assign a_dig  = active ? a[2*i +: 2] : 2'b00;
        assign slice_p[i] = mfu2(a_dig, digit, {a_signed & top, digit_signed});
    end

    always_comb begin
        row = '0;
        for (int i = 0; i < ND; i++) begin
            row = row + (RW'(slice_p[i]) <<< (2 * i));
        end
    end

endmodule

// File: rtl/ps_mac_seq.sv
// Precision-scalable digit-serial multiply-accumulate unit.
// One 2-bit digit of B is multiplied against all of A per cycle; after D
// digits the product is added into a wrapping dot-product accumulator.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : ps_mac_if slave (operand handshake in, result handshake out)
module ps_mac_seq
    import ps_mac_pkg::*;
#(
    parameter int MAX_W = 8,
    parameter int ACC_W = 32
) (
    input  logic    clk,
    input  logic    rst,
    ps_mac_if.slave bus
);
    localparam int PW  = 2 * MAX_W + 2;
    localparam int J_W = $clog2(MAX_W);

    state_t                  state_q;
    state_t                  state_d;
    logic [MAX_W-1:0]        a_q;
    logic [MAX_W-1:0]        b_q;
    logic [1:0]              sgn_q;
    logic                    clr_q;
    logic                    last_q;
    logic [J_W-1:0]          nd_q;
    logic [J_W-1:0]          j_q;
    logic signed [PW-1:0]    partial_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] partial_ext;
    logic signed [MAX_W+2:0] row;
    logic [1:0]              b_dig;
    logic                    last_dig;
    logic                    in_ready;
    logic                    out_valid;

    assign last_dig    = (j_q == nd_q - 1'b1);
    assign b_dig       = 2'(b_q >> {j_q, 1'b0});
    assign partial_ext = ACC_W'(partial_q);

    // Only the top digit of B carries the sign when B is signed.
    ps_digit_row #(.MAX_W(MAX_W)) u_row (
        .a            (a_q),
        .digit        (b_dig),
        .a_signed     (sgn_q[1]),
        .digit_signed (sgn_q[0] & last_dig),
        .n_digits     (nd_q),
        .row          (row)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = MUL;
            end
            MUL: begin
                if (last_dig) state_d = ACC;
            end
            ACC: begin
                state_d = last_q ? OUT : IDLE;
            end
            OUT: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= '0;
            clr_q     <= 1'b0;
            last_q    <= 1'b0;
            nd_q      <= '0;
            j_q       <= '0;
            partial_q <= '0;
            acc_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q       <= bus.a;
                        b_q       <= bus.b;
                        sgn_q     <= bus.sgn;
                        clr_q     <= bus.acc_clr;
                        last_q    <= bus.last;
                        nd_q      <= J_W'(eff_digits(bus.prec, MAX_W));
                        j_q       <= '0;
                        partial_q <= '0;
                    end
                end
                MUL: begin
                    partial_q <= partial_q + (PW'(row) <<< {j_q, 1'b0});
                    j_q       <= j_q + 1'b1;
                end
                ACC: begin
                    // Wraps modulo 2^ACC_W by construction.
                    if (clr_q) acc_q <= partial_ext;
                    else       acc_q <= acc_q + partial_ext;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.acc_out   = acc_q;

endmodule

// File: tb/tb_ps_mac_seq.sv
module tb_ps_mac_seq;
    localparam int MAX_W = 8;
    localparam int ACC_W = 32;
    localparam int TMO   = 100;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [ACC_W-1:0] m_acc;

    ps_mac_if #(.MAX_W(MAX_W), .ACC_W(ACC_W)) bus ();

    ps_mac_seq #(.MAX_W(MAX_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: operand width and value from the prec/sgn rules.
    function automatic int eff_w(input logic [1:0] prec);
        int w;
        w = 2 << prec;
        return (w > MAX_W) ? MAX_W : w;
    endfunction

    function automatic longint opval(input logic [7:0] x, input int w, input bit s);
        longint v;
        v = longint'(x) & ((longint'(1) << w) - 1);
        if (s && v[w-1]) v = v - (longint'(1) << w);
        return v;
    endfunction

    task automatic drive_pair(input logic [7:0] a, input logic [7:0] b,
                              input logic [1:0] prec, input logic [1:0] sgn,
                              input logic clr, input logic lst);
        longint p;
        int     w;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.prec     = prec;
        bus.sgn      = sgn;
        bus.acc_clr  = clr;
        bus.last     = lst;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        w = eff_w(prec);
        p = opval(a, w, sgn[1]) * opval(b, w, sgn[0]);
        m_acc = (clr ? '0 : m_acc) + ACC_W'(p);
    endtask

    // Edges after the accepting edge until out_valid is seen (-1 on timeout).
    task automatic wait_out(output int n, output bit ir_seen);
        n = -1;
        ir_seen = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            @(posedge clk); #1;
            if (bus.in_ready) ir_seen = 1'b1;
            if (bus.out_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_ready(output int n, output bit ov_seen);
        n = -1;
        ov_seen = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) ov_seen = 1'b1;
            if (bus.in_ready) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.acc_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_acc: got %h expected 0", bus.acc_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_acc = '0;
    endtask

    task automatic test_single_products();
        logic [7:0]  ta   [5] = '{8'h80, 8'hFF, 8'hF3, 8'h80, 8'h80};
        logic [7:0]  tb_  [5] = '{8'h80, 8'hFF, 8'h13, 8'hFF, 8'h7F};
        logic [1:0]  tp   [5] = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b11};
        logic [1:0]  ts   [5] = '{2'b11, 2'b10, 2'b00, 2'b10, 2'b11};
        logic [31:0] texp [5] = '{32'h00004000, 32'hFFFFFF01, 32'h9, 32'hFFFF8080, 32'hFFFFC080};
        int          tlat [5] = '{5, 5, 2, 5, 5};
        int n;
        bit irs;
        for (int t = 0; t < 5; t++) begin
            drive_pair(ta[t], tb_[t], tp[t], ts[t], 1'b1, 1'b1);
            wait_out(n, irs);
            checks++;
            if (n !== tlat[t]) begin
                failures++;
                $display("FAIL single_latency[%0d]: got %0d expected %0d", t, n, tlat[t]);
            end
            checks++;
            if (irs !== 1'b0) begin
                failures++;
                $display("FAIL single_in_ready_busy[%0d]: got %b expected 0", t, irs);
            end
            checks++;
            if (bus.acc_out !== texp[t]) begin
                failures++;
                $display("FAIL single_acc[%0d]: got %h expected %h", t, bus.acc_out, texp[t]);
            end
            drain();
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL single_drain[%0d]: got in_ready=%b out_valid=%b expected 1/0",
                         t, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_accumulate();
        int n;
        bit seen;
        drive_pair(8'h07, 8'h08, 2'b01, 2'b11, 1'b1, 1'b0);
        wait_ready(n, seen);
        checks++;
        if (n !== 3 || seen !== 1'b0) begin
            failures++;
            $display("FAIL acc_pair0: got gap=%0d out_valid_seen=%b expected 3/0", n, seen);
        end
        drive_pair(8'h08, 8'h08, 2'b01, 2'b11, 1'b0, 1'b0);
        wait_ready(n, seen);
        checks++;
        if (n !== 3 || seen !== 1'b0) begin
            failures++;
            $display("FAIL acc_pair1: got gap=%0d out_valid_seen=%b expected 3/0", n, seen);
        end
        drive_pair(8'h03, 8'h02, 2'b01, 2'b11, 1'b0, 1'b1);
        wait_out(n, seen);
        checks++;
        if (n !== 3 || bus.acc_out !== 32'd14) begin
            failures++;
            $display("FAIL acc_result: got lat=%0d acc=%0d expected 3/14", n, bus.acc_out);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int n;
        bit irs;
        drive_pair(8'h05, 8'h06, 2'b01, 2'b00, 1'b1, 1'b1);
        wait_out(n, irs);
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL bp_latency: got %0d expected 3", n);
        end
        // Stray operands during OUT must be ignored.
        bus.in_valid = 1'b1;
        bus.acc_clr  = 1'b1;
        bus.last     = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.acc_out !== 32'd30) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b acc=%0d expected 1/0/30",
                         k, bus.out_valid, bus.in_ready, bus.acc_out);
            end
        end
        bus.in_valid = 1'b0;
        drain();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1",
                     bus.out_valid, bus.in_ready);
        end
        // Accumulator persists: 30 + 2*3 = 36.
        drive_pair(8'h02, 8'h03, 2'b01, 2'b00, 1'b0, 1'b1);
        wait_out(n, irs);
        checks++;
        if (bus.acc_out !== 32'd36) begin
            failures++;
            $display("FAIL bp_continue: got %0d expected 36", bus.acc_out);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int n;
        bit irs;
        bit ov;
        drive_pair(8'h80, 8'h80, 2'b10, 2'b11, 1'b1, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.acc_out !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid: got out_valid=%b in_ready=%b acc=%h expected 0/1/0",
                     bus.out_valid, bus.in_ready, bus.acc_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_acc = '0;
        ov = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) ov = 1'b1;
        end
        checks++;
        if (ov !== 1'b0) begin
            failures++;
            $display("FAIL rst_discard: got out_valid seen=%b expected 0", ov);
        end
        drive_pair(8'h05, 8'h03, 2'b01, 2'b00, 1'b0, 1'b1);
        wait_out(n, irs);
        checks++;
        if (n !== 3 || bus.acc_out !== 32'd15) begin
            failures++;
            $display("FAIL rst_after: got lat=%0d acc=%0d expected 3/15", n, bus.acc_out);
        end
        drain();
    endtask

    task automatic test_random();
        int n;
        int len;
        int d;
        int hold;
        bit seen;
        logic [1:0] pr;
        logic [1:0] sg;
        logic clr;
        logic lst;
        for (int t = 0; t < 40; t++) begin
            len = $urandom_range(1, 4);
            for (int p = 0; p < len; p++) begin
                pr  = 2'($urandom_range(0, 3));
                sg  = 2'($urandom_range(0, 3));
                clr = (p == 0) ? ($urandom_range(0, 4) != 0) : 1'b0;
                lst = (p == len - 1);
                d   = eff_w(pr) / 2;
                drive_pair(8'($urandom), 8'($urandom), pr, sg, clr, lst);
                if (lst) begin
                    wait_out(n, seen);
                    checks++;
                    if (n !== d + 1 || seen !== 1'b0) begin
                        failures++;
                        $display("FAIL rnd_latency[%0d]: got %0d ready_seen=%b expected %0d/0",
                                 t, n, seen, d + 1);
                    end
                    checks++;
                    if (bus.acc_out !== m_acc) begin
                        failures++;
                        $display("FAIL rnd_acc[%0d]: got %h expected %h", t, bus.acc_out, m_acc);
                    end
                    hold = $urandom_range(0, 3);
                    for (int k = 0; k < hold; k++) begin
                        @(posedge clk); #1;
                    end
                    drain();
                    checks++;
                    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL rnd_drain[%0d]: got in_ready=%b out_valid=%b expected 1/0",
                                 t, bus.in_ready, bus.out_valid);
                    end
                end else begin
                    wait_ready(n, seen);
                    checks++;
                    if (n !== d + 1 || seen !== 1'b0) begin
                        failures++;
                        $display("FAIL rnd_gap[%0d.%0d]: got %0d out_valid_seen=%b expected %0d/0",
                                 t, p, n, seen, d + 1);
                    end
                end
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.prec      = '0;
        bus.sgn       = '0;
        bus.acc_clr   = 1'b0;
        bus.last      = 1'b0;
        bus.out_ready = 1'b0;
        m_acc         = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_single_products();
        test_accumulate();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
